// File: rtl/hs4_rx_fifo_pkg.sv
// ----------------------------------------------------------------------------
// hs4_pkg
// Shared definitions for the 4-phase push receiver with local FIFO.
//   - hs4_state_e      : handshake FSM state encodings
//   - SYNC_STAGES_MIN/MAX : legal synchroniser depths
//   - clog2()          : ceiling log2 usable in parameter expressions
// ----------------------------------------------------------------------------
package hs4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        STALL = 2'b01,
        ACK   = 2'b10
    } hs4_state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Bounded loop keeps this usable both at elaboration and in synthesis.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hs4_rx_fifo_sync.sv
// ----------------------------------------------------------------------------
// sync_nff
// STAGES-deep flop chain bringing an asynchronous level into the clk domain.
// Ports:
//   clk   : destination clock
//   reset : asynchronous active-high reset, clears every stage to 0
//   d     : asynchronous input level
//   q     : synchronised level, STAGES clk edges behind d
// ----------------------------------------------------------------------------
module sync_nff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the chain; only the last stage is used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/hs4_rx_fifo.sv
// ----------------------------------------------------------------------------
// hs4_rx_fifo
// Receives words from a foreign clock domain over a 4-phase req/ack
// handshake and buffers them in a DEPTH-entry FIFO drained by a valid/ready
// consumer. ack is withheld while the FIFO is full (backpressure).
//
// Parameters: DATA_W, SYNC_STAGES (2..4), DEPTH (power of two, >= 2), CNT_W
// Ports:
//   clk, reset  : local clock, asynchronous active-high reset
//   req         : 4-phase request from the sender (asynchronous)
//   input_rx    : bundled data, stable from req rise until ack rise
//   ack         : registered 4-phase acknowledge
//   out_valid   : FIFO non-empty
//   out_data    : FIFO head word (0 while empty)
//   out_ready   : consumer pops the head on out_valid & out_ready
//   level       : FIFO occupancy
//   xfer_cnt    : completed handshakes, wraps   (HS4_RX_STATS_EN only)
//   ovf_stall   : sticky, FIFO ever stalled a sender (HS4_RX_STATS_EN only)
//
// Optional feature macro: HS4_RX_STATS_EN
// ----------------------------------------------------------------------------
module hs4_rx_fifo
    import hs4_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [DATA_W-1:0]     input_rx,
    output logic                  ack,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  out_ready,
    output logic [clog2(DEPTH):0] level
`ifdef HS4_RX_STATS_EN
    ,
    output logic [CNT_W-1:0]      xfer_cnt,
    output logic                  ovf_stall
`endif
);

    localparam int AW    = clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic              req_s;
    hs4_state_e        state;
    hs4_state_e        state_d;
    logic              ack_d;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    // req is only ever looked at through the synchroniser.
    sync_nff #(
        .STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (req),
        .q     (req_s)
    );

    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    assign pop       = out_valid & out_ready;
    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];

    // Handshake FSM. full is the registered occupancy, so a pop that frees
    // space becomes visible to STALL one cycle later (no same-cycle bypass).
    always_comb begin
        state_d = state;
        ack_d   = 1'b0;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (req_s) begin
                    if (!full) begin
                        push    = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (!full) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (req_s) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ack has its own flop so it is glitch-free toward the sender domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ack   <= 1'b0;
        end else begin
            state <= state_d;
            ack   <= ack_d;
        end
    end

    // Pointers wrap naturally at DEPTH; level carries the extra bit that
    // separates full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= input_rx;
        end
    end

`ifdef HS4_RX_STATS_EN
    // Count completed handshakes and remember whether a sender was stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_cnt  <= '0;
            ovf_stall <= 1'b0;
        end else begin
            if (state == ACK && state_d == IDLE) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            if (state != STALL && state_d == STALL) begin
                ovf_stall <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hs4_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_hs4_rx_fifo
// Self-checking bench for hs4_rx_fifo. A second instance with
// SYNC_STAGES=4 covers the deeper synchroniser. Stats checks are compiled
// when HS4_RX_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_hs4_rx_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       req;
    logic [7:0] input_rx;
    logic       ack;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] level;
`ifdef HS4_RX_STATS_EN
    logic [3:0] xfer_cnt;
    logic       ovf_stall;
`endif

    logic       req4;
    logic [7:0] input_rx4;
    logic       ack4;
    logic       out_valid4;
    logic [7:0] out_data4;
    logic       out_ready4;
    logic [2:0] level4;
`ifdef HS4_RX_STATS_EN
    logic [15:0] xfer_cnt4;
    logic        ovf_stall4;
`endif

    int checks = 0;
    int errors = 0;

    hs4_rx_fifo #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .DEPTH       (DEPTH),
`ifdef HS4_RX_STATS_EN
        .CNT_W       (4)
`else
        .CNT_W       (16)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .input_rx  (input_rx),
        .ack       (ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level)
`ifdef HS4_RX_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt),
        .ovf_stall (ovf_stall)
`endif
    );

    hs4_rx_fifo #(
        .DATA_W      (8),
        .SYNC_STAGES (4),
        .DEPTH       (DEPTH),
        .CNT_W       (16)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .req       (req4),
        .input_rx  (input_rx4),
        .ack       (ack4),
        .out_valid (out_valid4),
        .out_data  (out_data4),
        .out_ready (out_ready4),
        .level     (level4)
`ifdef HS4_RX_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt4),
        .ovf_stall (ovf_stall4)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts negedges until the selected ack reaches target; -1 on timeout.
    task automatic wait_ack(input logic target, input bit use4, output int cycles);
        cycles = 0;
        while (((use4 ? ack4 : ack) !== target) && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        if ((use4 ? ack4 : ack) !== target) cycles = -1;
    endtask

    // Full 4-phase handshake on the main instance.
    task automatic send_word(input logic [7:0] d, output int rise, output int fall);
        input_rx = d;
        req      = 1'b1;
        wait_ack(1'b1, 1'b0, rise);
        req = 1'b0;
        wait_ack(1'b0, 1'b0, fall);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: ack=%b valid=%b data=%h level=%0d, required 0/0/00/0",
                     ack, out_valid, out_data, level);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_transfer;
        int rise, fall;
        input_rx = 8'hA5;
        req      = 1'b1;
        wait_ack(1'b1, 1'b0, rise);
        checks++;
        if (rise != 3) begin
            errors++;
            $display("[TB] FAIL single_rise_latency: got %0d, required 3", rise);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || level !== 3'd1) begin
            errors++;
            $display("[TB] FAIL single_data: valid=%b data=%h level=%0d, required 1/a5/1",
                     out_valid, out_data, level);
        end
        req = 1'b0;
        wait_ack(1'b0, 1'b0, fall);
        checks++;
        if (fall != 3) begin
            errors++;
            $display("[TB] FAIL single_fall_latency: got %0d, required 3", fall);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (level !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drain: level=%0d valid=%b, required 0/0", level, out_valid);
        end
    endtask

    task automatic test_backpressure;
        int rise, fall;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_word(8'(i), rise, fall);
            checks++;
            if (rise != 3 || fall != 3) begin
                errors++;
                $display("[TB] FAIL bp_handshake_%0d: rise=%0d fall=%0d, required 3/3", i, rise, fall);
            end
        end
        input_rx = 8'h05;
        req      = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (ack !== 1'b0 || level !== 3'd4 || out_data !== 8'h01) begin
            errors++;
            $display("[TB] FAIL bp_stall: ack=%b level=%0d data=%h, required 0/4/01", ack, level, out_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (ack !== 1'b0 || level !== 3'd3 || out_data !== 8'h02) begin
            errors++;
            $display("[TB] FAIL bp_pop: ack=%b level=%0d data=%h, required 0/3/02", ack, level, out_data);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b1 || level !== 3'd4) begin
            errors++;
            $display("[TB] FAIL bp_release: ack=%b level=%0d, required 1/4", ack, level);
        end
        req = 1'b0;
        wait_ack(1'b0, 1'b0, fall);
        checks++;
        if (fall != 3) begin
            errors++;
            $display("[TB] FAIL bp_fall_latency: got %0d, required 3", fall);
        end
        for (int i = 2; i <= 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                errors++;
                $display("[TB] FAIL bp_drain_%0d: valid=%b data=%h, required 1/%h", i, out_valid, out_data, 8'(i));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        checks++;
        if (level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL bp_empty: level=%0d, required 0", level);
        end
    endtask

    task automatic test_simul_push_pop;
        int rise, fall;
        send_word(8'h10, rise, fall);
        send_word(8'h11, rise, fall);
        input_rx = 8'h12;
        req      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (ack !== 1'b1 || level !== 3'd2 || out_data !== 8'h11) begin
            errors++;
            $display("[TB] FAIL push_pop_same_cycle: ack=%b level=%0d data=%h, required 1/2/11",
                     ack, level, out_data);
        end
        req = 1'b0;
        wait_ack(1'b0, 1'b0, fall);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_data !== 8'(8'h11 + i)) begin
                errors++;
                $display("[TB] FAIL push_pop_order_%0d: data=%h, required %h", i, out_data, 8'(8'h11 + i));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        int rise, fall;
        send_word(8'h31, rise, fall);
        send_word(8'h32, rise, fall);
        input_rx = 8'h33;
        req      = 1'b1;
        wait_ack(1'b1, 1'b0, rise);
        checks++;
        if (level !== 3'd3 || ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_setup: level=%0d ack=%b, required 3/1", level, ack);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0 || out_valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid_async: ack=%b valid=%b level=%0d, required 0/0/0", ack, out_valid, level);
        end
        @(negedge clk);
        reset = 1'b0;
        wait_ack(1'b1, 1'b0, rise);
        checks++;
        if (rise != 3 || level !== 3'd1 || out_data !== 8'h33) begin
            errors++;
            $display("[TB] FAIL rst_mid_recapture: rise=%0d level=%0d data=%h, required 3/1/33",
                     rise, level, out_data);
        end
        req = 1'b0;
        wait_ack(1'b0, 1'b0, fall);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_sync_depth;
        int rise, fall;
        input_rx4 = 8'h5A;
        req4      = 1'b1;
        wait_ack(1'b1, 1'b1, rise);
        checks++;
        if (rise != 5 || out_data4 !== 8'h5A || level4 !== 3'd1) begin
            errors++;
            $display("[TB] FAIL sync4_rise: rise=%0d data=%h level=%0d, required 5/5a/1", rise, out_data4, level4);
        end
        req4 = 1'b0;
        wait_ack(1'b0, 1'b1, fall);
        checks++;
        if (fall != 5) begin
            errors++;
            $display("[TB] FAIL sync4_fall: got %0d, required 5", fall);
        end
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        checks++;
        if (level4 !== 3'd0) begin
            errors++;
            $display("[TB] FAIL sync4_drain: level=%0d, required 0", level4);
        end
    endtask

    // Random sender and consumer against an ordered-queue model of the FIFO.
    task automatic test_random;
        logic [7:0] model_q[$];
        logic [7:0] cur;
        int         sent;
        int         cycles;
        bit         prev_ack;
        bit         prev_pop;
        sent     = 0;
        cycles   = 0;
        prev_ack = 1'b0;
        prev_pop = 1'b0;
        cur      = 8'h00;
        while ((sent < 40 || model_q.size() != 0 || req || ack) && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            if (prev_pop) void'(model_q.pop_front());
            if (ack && !prev_ack) model_q.push_back(cur);
            prev_ack = ack;
            checks++;
            if (level !== 3'(model_q.size()) || out_valid !== (model_q.size() != 0) || model_q.size() > DEPTH) begin
                errors++;
                $display("[TB] FAIL rand_level: level=%0d valid=%b, required %0d", level, out_valid, model_q.size());
            end
            if (model_q.size() != 0) begin
                checks++;
                if (out_data !== model_q[0]) begin
                    errors++;
                    $display("[TB] FAIL rand_data: data=%h, required %h", out_data, model_q[0]);
                end
            end
            if (req && ack) begin
                req = 1'b0;
            end else if (!req && !ack && sent < 40 && $urandom_range(0, 2) == 0) begin
                cur      = 8'($urandom);
                input_rx = cur;
                req      = 1'b1;
                sent++;
            end
            if ((cycles % 200) < 100) out_ready = ($urandom_range(0, 4) == 0);
            else                      out_ready = ($urandom_range(0, 1) == 1);
            prev_pop = (model_q.size() != 0) && out_ready;
        end
        out_ready = 1'b0;
        checks++;
        if (cycles >= 4000 || sent != 40) begin
            errors++;
            $display("[TB] FAIL rand_timeout: cycles=%0d sent=%0d, required <4000/40", cycles, sent);
        end
    endtask

`ifdef HS4_RX_STATS_EN
    task automatic test_stats;
        int rise, fall;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (xfer_cnt !== 4'd0 || ovf_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stats_reset: cnt=%0d ovf=%b, required 0/0", xfer_cnt, ovf_stall);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send_word(8'(i), rise, fall);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (xfer_cnt !== 4'd1 || ovf_stall !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL stats_wrap: cnt=%0d ovf=%b level=%0d, required 1/0/0", xfer_cnt, ovf_stall, level);
        end
        for (int i = 0; i < 4; i++) send_word(8'(i), rise, fall);
        input_rx = 8'hEE;
        req      = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (ovf_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stats_ovf: ovf=%b, required 1", ovf_stall);
        end
        out_ready = 1'b1;
        wait_ack(1'b1, 1'b0, rise);
        req = 1'b0;
        wait_ack(1'b0, 1'b0, fall);
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        reset      = 1'b1;
        req        = 1'b0;
        input_rx   = 8'h00;
        out_ready  = 1'b0;
        req4       = 1'b0;
        input_rx4  = 8'h00;
        out_ready4 = 1'b0;
        test_reset();
        test_single_transfer();
        test_backpressure();
        test_simul_push_pop();
        test_reset_mid();
        test_sync_depth();
        test_random();
`ifdef HS4_RX_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
